router_engine: RTL

Parametrised successor to the single-port router state machine. It has the same OFFLINE→CONFIG→READY→CHECKSUM→ACK→LOOKUP→TRANSMIT→CONFIRM flow. New in this generation: generic widths, a sliced multi-cycle popcount checksum, a configurable route mask, a configurable confirm timeout and retry budget, local delivery for packets addressed to this router, and saturating counters. It sits between the link receive interface and the downstream transmit port.

---
 rtl/router_pkg.sv | 37 +++
 rtl/router_engine_if.sv | 38 +++
 rtl/router_popcount.sv | 20 ++
 rtl/router_engine.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types, default parameters and helpers for the router engine.
//   router_state_e : FSM state encoding
//   Def*           : default parameter values
//   popcount()     : ones-count of a vector of up to MaxPopLanes bits
package router_pkg;

  localparam int unsigned DefDataW      = 32;
  localparam int unsigned DefAddrW      = 12;
  localparam int unsigned DefPopLanes   = 8;
  localparam int unsigned DefAckTimeout = 2;
  localparam int unsigned DefMaxRetries = 1;
  localparam int unsigned DefCntW       = 16;
  localparam int unsigned MaxPopLanes   = 64;

  typedef enum logic [3:0] {
    OFFLINE,
    CONFIG,
    READY,
    CHECKSUM,
    ACK,
    LOOKUP,
    TRANSMIT,
    CONFIRM,
    RETRY,
    ERROR
  } router_state_e;

  function automatic int unsigned popcount(input logic [MaxPopLanes-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MaxPopLanes; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/router_engine_if.sv
// Link-side and transmit-side signal bundle of the router engine.
//   slave  : view taken by router_engine (inputs from link, outputs to tx port)
//   master : view taken by whatever drives the link (e.g. a bench)
interface router_engine_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned HDR_W  = $clog2(DATA_W + 1),
  parameter int unsigned CNT_W  = 16
);
  logic              config_in;
  logic              receive;
  logic [HDR_W-1:0]  header_in;
  logic [ADDR_W-1:0] address_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_in;
  logic              ready;
  logic              ack_out;
  logic              lookup;
  logic              transmit;
  logic              bad_packet;
  logic              local_deliver;
  logic [ADDR_W-1:0] address_out;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  packets_ok;
  logic [CNT_W-1:0]  packets_fail;

  modport slave (
    input  config_in, receive, header_in, address_in, data_in, ack_in,
    output ready, ack_out, lookup, transmit, bad_packet, local_deliver,
           address_out, data_out, packets_ok, packets_fail
  );

  modport master (
    output config_in, receive, header_in, address_in, data_in, ack_in,
    input  ready, ack_out, lookup, transmit, bad_packet, local_deliver,
           address_out, data_out, packets_ok, packets_fail
  );
endinterface

// File: rtl/router_popcount.sv
// Combinational ones-count of one checksum slice.
//   bits_i  : Lanes-bit slice
//   count_o : number of set bits in bits_i
module router_popcount import router_pkg::*; #(
  parameter int unsigned Lanes  = DefPopLanes,
  parameter int unsigned CountW = $clog2(Lanes + 1)
) (
  input  logic [Lanes-1:0]  bits_i,
  output logic [CountW-1:0] count_o
);

  if (Lanes > MaxPopLanes) begin : g_chk_lanes
    $error("router_popcount: Lanes exceeds MaxPopLanes");
  end

  always_comb begin
    count_o = CountW'(popcount(MaxPopLanes'(bits_i)));
  end

endmodule

// File: rtl/router_engine.sv
// Single-port packet router: configure, checksum, route, transmit with retries.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : router_engine_if.slave -- link inputs (config_in, receive,
//                header_in, address_in, data_in, ack_in) and state-decoded
//                strobes, routed address/payload and saturating counters
module router_engine import router_pkg::*; #(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned HDR_W       = $clog2(DATA_W + 1),
  parameter int unsigned POP_LANES   = DefPopLanes,
  parameter int unsigned ACK_TIMEOUT = DefAckTimeout,
  parameter int unsigned MAX_RETRIES = DefMaxRetries,
  parameter int unsigned CNT_W       = DefCntW
) (
  input logic      clk,
  input logic      reset,
  router_engine_if.slave bus
);

  localparam int unsigned NumSlices = DATA_W / POP_LANES;
  localparam int unsigned SliceW    = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam int unsigned PopW      = $clog2(POP_LANES + 1);
  localparam int unsigned TimerW    = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned RetryW    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  if (DATA_W % POP_LANES != 0) begin : g_chk_lanes
    $error("router_engine: DATA_W must be a multiple of POP_LANES");
  end
  if (DATA_W < 2 * ADDR_W) begin : g_chk_width
    $error("router_engine: DATA_W must be at least 2*ADDR_W");
  end
  if (ACK_TIMEOUT < 1) begin : g_chk_timeout
    $error("router_engine: ACK_TIMEOUT must be at least 1");
  end

  router_state_e     state_q;
  logic [ADDR_W-1:0] own_addr_q, route_mask_q, addr_q, addr_out_q;
  logic [HDR_W-1:0]  hdr_q, acc_q;
  logic [DATA_W-1:0] data_q;
  logic [SliceW-1:0] slice_q;
  logic [TimerW-1:0] timer_q;
  logic [RetryW-1:0] retries_q;
  logic [CNT_W-1:0]  ok_q, fail_q;

  logic [POP_LANES-1:0] slice_bits;
  logic [PopW-1:0]      slice_cnt;
  logic [HDR_W-1:0]     acc_sum;
  logic                 is_local;

  // LSB slice first: slice_q walks upward through the latched payload.
  assign slice_bits = POP_LANES'(data_q >> (POP_LANES * 32'(slice_q)));
  assign acc_sum    = acc_q + HDR_W'(slice_cnt);
  assign is_local   = (addr_q == own_addr_q);

  router_popcount #(
    .Lanes (POP_LANES),
    .CountW(PopW)
  ) u_popcount (
    .bits_i (slice_bits),
    .count_o(slice_cnt)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= OFFLINE;
      own_addr_q   <= '0;
      route_mask_q <= '0;
      addr_q       <= '0;
      addr_out_q   <= '0;
      hdr_q        <= '0;
      acc_q        <= '0;
      data_q       <= '0;
      slice_q      <= '0;
      timer_q      <= '0;
      retries_q    <= '0;
      ok_q         <= '0;
      fail_q       <= '0;
    end else begin
      case (state_q)
        OFFLINE: begin
          if (bus.config_in) state_q <= CONFIG;
        end
        CONFIG: begin
          if (bus.receive) begin
            // A zero own address is not a valid configuration.
            if (bus.data_in[ADDR_W-1:0] == '0) begin
              state_q <= OFFLINE;
            end else begin
              own_addr_q   <= bus.data_in[ADDR_W-1:0];
              route_mask_q <= bus.data_in[2*ADDR_W-1:ADDR_W];
              state_q      <= READY;
            end
          end
        end
        READY: begin
          if (bus.config_in) begin
            state_q <= CONFIG;
          end else if (bus.receive) begin
            hdr_q     <= bus.header_in;
            addr_q    <= bus.address_in;
            data_q    <= bus.data_in;
            acc_q     <= '0;
            slice_q   <= '0;
            retries_q <= '0;
            state_q   <= CHECKSUM;
          end
        end
        CHECKSUM: begin
          acc_q <= acc_sum;
          if (slice_q == SliceW'(NumSlices - 1)) begin
            state_q <= (acc_sum == hdr_q) ? ACK : ERROR;
          end else begin
            slice_q <= slice_q + SliceW'(1);
          end
        end
        ACK: begin
          if (is_local) begin
            ok_q    <= sat_inc(ok_q);
            state_q <= READY;
          end else begin
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          addr_out_q <= addr_q & route_mask_q;
          state_q    <= TRANSMIT;
        end
        TRANSMIT: begin
          timer_q <= '0;
          state_q <= CONFIRM;
        end
        CONFIRM: begin
          if (bus.ack_in) begin
            ok_q    <= sat_inc(ok_q);
            state_q <= READY;
          end else if (timer_q == TimerW'(ACK_TIMEOUT - 1)) begin
            state_q <= (retries_q < RetryW'(MAX_RETRIES)) ? RETRY : ERROR;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        RETRY: begin
          retries_q <= retries_q + RetryW'(1);
          if (bus.ack_in) begin
            ok_q    <= sat_inc(ok_q);
            state_q <= READY;
          end else begin
            state_q <= TRANSMIT;
          end
        end
        ERROR: begin
          fail_q  <= sat_inc(fail_q);
          state_q <= READY;
        end
        default: state_q <= OFFLINE;
      endcase
    end
  end

  assign bus.ready         = (state_q == READY);
  assign bus.ack_out       = (state_q == ACK);
  assign bus.lookup        = (state_q == LOOKUP);
  assign bus.transmit      = (state_q == TRANSMIT);
  assign bus.bad_packet    = (state_q == ERROR);
  assign bus.local_deliver = (state_q == ACK) && is_local;
  assign bus.address_out   = addr_out_q;
  assign bus.data_out      = data_q;
  assign bus.packets_ok    = ok_q;
  assign bus.packets_fail  = fail_q;

endmodule
